// File: rtl/fm_sb_playback_if.sv
// Word-addressed memory-port bus used by software to load and read back
// playback entries.
interface fm_sb_playback_if #(
    parameter int ADDR_W = 16,
    parameter int AXI_DW = 32
);
    logic [ADDR_W-1:0] axi_addr;
    logic              axi_enable;
    logic              axi_wr_enable;
    logic [AXI_DW-1:0] axi_wr_data;
    logic [AXI_DW-1:0] axi_rd_data;
    logic              axi_rd_vld;
    logic              axi_wr_err;

    modport master (
        output axi_addr, axi_enable, axi_wr_enable, axi_wr_data,
        input  axi_rd_data, axi_rd_vld, axi_wr_err
    );

    modport slave (
        input  axi_addr, axi_enable, axi_wr_enable, axi_wr_data,
        output axi_rd_data, axi_rd_vld, axi_wr_err
    );
endinterface

// File: rtl/fm_sb_playback.sv
// Fast-monitor playback buffer: software loads entries word by word over the
// memory port, then the FSM replays them as a gapless fm_data/fm_vld stream.
module fm_sb_playback #(
    parameter int   MON_DW = 256,
    parameter int   AXI_DW = 32,
    parameter int   DEPTH  = 64,
    parameter int   ADDR_W = 16,
    localparam int  PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    fm_sb_playback_if.slave   axi,
    input  logic [1:0]        pb_mode,
    input  logic              pb_start,
    input  logic              pb_stop,
    input  logic [PTR_W:0]    pb_length,
    output logic [MON_DW-1:0] fm_data,
    output logic              fm_vld,
    output logic              pb_busy,
    output logic              pb_done,
    output logic [15:0]       loop_count
);
    localparam int                WPE        = MON_DW / AXI_DW;
    localparam int                WSEL_W     = (WPE > 1) ? $clog2(WPE) : 1;
    localparam logic [ADDR_W-1:0] WPE_A      = ADDR_W'(WPE);
    localparam logic [31:0]       ADDR_LIMIT = 32'(DEPTH * WPE);
    localparam logic [PTR_W:0]    LEN_MAX    = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    len_reg;
    logic              loop_mode_reg;
    logic [15:0]       loop_count_reg;
    logic              fm_vld_reg;
    logic              pb_done_reg;
    logic              wr_err_reg;
    logic              rd_vld_reg;
    logic              rd_ok_reg;
    logic [WSEL_W-1:0] rd_word_reg;

    logic [PTR_W-1:0]  addr_entry;
    logic [WSEL_W-1:0] addr_word;
    logic              addr_ok;
    logic              wr_req;
    logic              rd_req;
    logic              wr_hit;
    logic              busy;
    logic              pb_issue;
    logic              last_issue;
    logic              start_ok;

    logic [WPE*AXI_DW-1:0] axi_words;
    logic [MON_DW-1:0]     pb_words;

    assign addr_entry = PTR_W'(axi.axi_addr / WPE_A);
    assign addr_word  = WSEL_W'(axi.axi_addr % WPE_A);
    assign addr_ok    = 32'(axi.axi_addr) < ADDR_LIMIT;
    assign wr_req     = axi.axi_enable && axi.axi_wr_enable;
    assign rd_req     = axi.axi_enable && !axi.axi_wr_enable;
    assign busy       = (state_reg != ST_IDLE);
    // Software may not rewrite memory while it is being replayed.
    assign wr_hit     = wr_req && addr_ok && !busy;

    // A stop suppresses the read that would otherwise be issued this cycle.
    assign pb_issue   = (state_reg == ST_PLAY) && !pb_stop;
    assign last_issue = ({1'b0, rd_ptr_reg} == (len_reg - 1'b1));
    assign start_ok   = pb_start && (pb_mode == 2'b01 || pb_mode == 2'b10)
                        && (pb_length != '0) && (pb_length <= LEN_MAX);

    // One narrow bank per word lane so a single AXI word write touches one bank.
    generate
        for (genvar gi = 0; gi < WPE; gi++) begin : g_bank
            logic [AXI_DW-1:0] mem [DEPTH];
            logic [AXI_DW-1:0] axi_q_reg;
            logic [AXI_DW-1:0] pb_q_reg;

            always_ff @(posedge clk) begin
                if (wr_hit && addr_word == WSEL_W'(gi))
                    mem[addr_entry] <= axi.axi_wr_data;
                if (rd_req)
                    axi_q_reg <= mem[addr_entry];
                if (pb_issue)
                    pb_q_reg <= mem[rd_ptr_reg];
            end

            assign axi_words[gi*AXI_DW +: AXI_DW] = axi_q_reg;
            assign pb_words[gi*AXI_DW +: AXI_DW]  = pb_q_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            rd_ptr_reg     <= '0;
            len_reg        <= '0;
            loop_mode_reg  <= 1'b0;
            loop_count_reg <= '0;
            fm_vld_reg     <= 1'b0;
            pb_done_reg    <= 1'b0;
            wr_err_reg     <= 1'b0;
            rd_vld_reg     <= 1'b0;
            rd_ok_reg      <= 1'b0;
            rd_word_reg    <= '0;
        end else begin
            wr_err_reg  <= wr_req && (!addr_ok || busy);
            rd_vld_reg  <= rd_req;
            if (rd_req) begin
                rd_ok_reg   <= addr_ok;
                rd_word_reg <= addr_word;
            end
            fm_vld_reg  <= pb_issue;
            pb_done_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_reg      <= ST_PLAY;
                        rd_ptr_reg     <= '0;
                        loop_count_reg <= '0;
                        len_reg        <= pb_length;
                        loop_mode_reg  <= (pb_mode == 2'b10);
                    end
                end
                ST_PLAY: begin
                    if (pb_stop) begin
                        // Nothing is issued now, so the last output is this cycle.
                        state_reg   <= ST_DRAIN;
                        pb_done_reg <= 1'b1;
                    end else if (last_issue) begin
                        if (loop_mode_reg) begin
                            rd_ptr_reg <= '0;
                            if (loop_count_reg != 16'hFFFF)
                                loop_count_reg <= loop_count_reg + 16'd1;
                        end else begin
                            state_reg <= ST_DRAIN;
                        end
                    end else begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    state_reg   <= ST_IDLE;
                    pb_done_reg <= fm_vld_reg;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign axi.axi_rd_data = rd_ok_reg ? axi_words[int'(rd_word_reg)*AXI_DW +: AXI_DW] : '0;
    assign axi.axi_rd_vld  = rd_vld_reg;
    assign axi.axi_wr_err  = wr_err_reg;
    assign fm_data         = fm_vld_reg ? pb_words : '0;
    assign fm_vld          = fm_vld_reg;
    assign pb_busy         = busy;
    assign pb_done         = pb_done_reg;
    assign loop_count      = loop_count_reg;
endmodule

// File: tb/tb_fm_sb_playback.sv
// Directed bench for fm_sb_playback: load/readback, single-shot, loop, stop,
// illegal starts, busy interactions and reset in the middle of a stream.
module tb_fm_sb_playback;
    localparam int MON_DW = 256;
    localparam int AXI_DW = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 16;
    localparam int PTR_W  = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fm_sb_playback_if #(.ADDR_W(ADDR_W), .AXI_DW(AXI_DW)) axi_bus ();

    logic [1:0]        pb_mode;
    logic              pb_start;
    logic              pb_stop;
    logic [PTR_W:0]    pb_length;
    logic [MON_DW-1:0] fm_data;
    logic              fm_vld;
    logic              pb_busy;
    logic              pb_done;
    logic [15:0]       loop_count;

    fm_sb_playback #(
        .MON_DW(MON_DW), .AXI_DW(AXI_DW), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .axi       (axi_bus),
        .pb_mode   (pb_mode),
        .pb_start  (pb_start),
        .pb_stop   (pb_stop),
        .pb_length (pb_length),
        .fm_data   (fm_data),
        .fm_vld    (fm_vld),
        .pb_busy   (pb_busy),
        .pb_done   (pb_done),
        .loop_count(loop_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] pat(int e, int k);
        return (32'(e) << 28) + 32'(k);
    endfunction

    function automatic logic [255:0] ent(int e);
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = pat(e, k);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic exp_err);
        axi_bus.axi_addr      = a;
        axi_bus.axi_wr_data   = d;
        axi_bus.axi_enable    = 1'b1;
        axi_bus.axi_wr_enable = 1'b1;
        tick();
        axi_bus.axi_enable    = 1'b0;
        axi_bus.axi_wr_enable = 1'b0;
        chk("wr_err", 256'(axi_bus.axi_wr_err), 256'(exp_err));
        $display("axi wr addr=%0d data=%h err=%b", a, d, axi_bus.axi_wr_err);
    endtask

    task automatic axi_read(input logic [15:0] a, input logic [31:0] exp);
        axi_bus.axi_addr      = a;
        axi_bus.axi_enable    = 1'b1;
        axi_bus.axi_wr_enable = 1'b0;
        tick();
        axi_bus.axi_enable    = 1'b0;
        chk("rd_vld", 256'(axi_bus.axi_rd_vld), 256'(1));
        chk("rd_data", 256'(axi_bus.axi_rd_data), 256'(exp));
        $display("axi rd addr=%0d data=%h vld=%b", a, axi_bus.axi_rd_data, axi_bus.axi_rd_vld);
    endtask

    initial begin
        logic [1:0]     bad_mode [4];
        logic [PTR_W:0] bad_len  [4];
        bad_mode[0] = 2'b01; bad_len[0] = 7'd0;
        bad_mode[1] = 2'b01; bad_len[1] = 7'd65;
        bad_mode[2] = 2'b00; bad_len[2] = 7'd3;
        bad_mode[3] = 2'b11; bad_len[3] = 7'd3;

        axi_bus.axi_addr      = '0;
        axi_bus.axi_enable    = 1'b0;
        axi_bus.axi_wr_enable = 1'b0;
        axi_bus.axi_wr_data   = '0;
        pb_mode   = 2'b00;
        pb_start  = 1'b0;
        pb_stop   = 1'b0;
        pb_length = '0;

        // Reset state
        tick();
        tick();
        chk("rst_ctl", 256'({fm_vld, pb_busy, pb_done}), 256'(0));
        chk("rst_lc", 256'(loop_count), 256'(0));
        chk("rst_axi", 256'({axi_bus.axi_rd_vld, axi_bus.axi_wr_err, axi_bus.axi_rd_data}), 256'(0));
        chk("rst_fm_data", fm_data, 256'(0));
        rst_n = 1'b1;
        tick();

        // Load entries 0..4 and read entry 3 back
        for (int e = 0; e < 5; e++)
            for (int k = 0; k < 8; k++)
                axi_write(16'(e*8 + k), pat(e, k), 1'b0);
        for (int k = 0; k < 8; k++)
            axi_read(16'(24 + k), pat(3, k));
        tick();
        chk("rd_vld_pulse", 256'(axi_bus.axi_rd_vld), 256'(0));
        chk("rd_data_hold", 256'(axi_bus.axi_rd_data), 256'(pat(3, 7)));
        axi_read(16'd512, 32'h0);
        axi_write(16'd512, 32'h5555_AAAA, 1'b1);
        tick();
        chk("wr_err_pulse", 256'(axi_bus.axi_wr_err), 256'(0));

        // Single-shot, length 5
        pb_mode = 2'b01; pb_length = 7'd5; pb_start = 1'b1;
        tick();
        pb_start = 1'b0;
        chk("ss_t1", 256'({fm_vld, pb_busy}), 256'(2'b01));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ss_vld", 256'(fm_vld), 256'(1));
            chk("ss_data", fm_data, ent(i));
        end
        tick();
        chk("ss_end", 256'({fm_vld, pb_done, pb_busy}), 256'(3'b010));
        tick();
        chk("ss_after", 256'({fm_vld, pb_done, pb_busy}), 256'(0));
        $display("single-shot pass complete");

        // Loop, length 3, stop on an end-of-pass cycle
        pb_mode = 2'b10; pb_length = 7'd3; pb_start = 1'b1;
        tick();
        pb_start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("lp_vld", 256'(fm_vld), 256'(1));
            chk("lp_data", fm_data, ent(i % 3));
            if (i == 9) chk("lp_count", 256'(loop_count), 256'(3));
        end
        pb_stop = 1'b1;
        tick();
        pb_stop = 1'b0;
        chk("lp_stop_drain", 256'({fm_vld, pb_done, pb_busy}), 256'(3'b011));
        chk("lp_stop_count", 256'(loop_count), 256'(3));
        tick();
        chk("lp_stop_idle", 256'({fm_vld, pb_done, pb_busy}), 256'(0));
        chk("lp_final_count", 256'(loop_count), 256'(3));
        $display("loop pass complete count=%0d", loop_count);

        // Illegal starts
        for (int t = 0; t < 4; t++) begin
            pb_mode = bad_mode[t]; pb_length = bad_len[t]; pb_start = 1'b1;
            tick();
            pb_start = 1'b0;
            for (int c = 0; c < 3; c++) begin
                chk("bad_start", 256'({fm_vld, pb_busy, pb_done}), 256'(0));
                tick();
            end
            $display("illegal start mode=%b len=%0d", bad_mode[t], bad_len[t]);
        end

        // Busy interactions: dropped write, read while playing, second start
        pb_mode = 2'b01; pb_length = 7'd5; pb_start = 1'b1;
        tick();
        axi_bus.axi_addr = 16'd0; axi_bus.axi_wr_data = 32'hDEAD_BEEF;
        axi_bus.axi_enable = 1'b1; axi_bus.axi_wr_enable = 1'b1;
        tick();
        pb_start = 1'b0;
        chk("busy_wr_err", 256'(axi_bus.axi_wr_err), 256'(1));
        chk("busy_data0", fm_data, ent(0));
        axi_bus.axi_addr = 16'd9; axi_bus.axi_wr_enable = 1'b0;
        tick();
        axi_bus.axi_enable = 1'b0;
        chk("busy_rd_vld", 256'(axi_bus.axi_rd_vld), 256'(1));
        chk("busy_rd_data", 256'(axi_bus.axi_rd_data), 256'(pat(1, 1)));
        chk("busy_data1", fm_data, ent(1));
        for (int i = 2; i < 5; i++) begin
            tick();
            chk("busy_data", fm_data, ent(i));
        end
        tick();
        chk("busy_done", 256'({pb_done, pb_busy}), 256'(2'b10));
        tick();
        chk("busy_no_restart", 256'({fm_vld, pb_busy}), 256'(0));
        axi_read(16'd0, pat(0, 0));
        $display("busy interactions complete");

        // Reset asserted during loop playback
        pb_mode = 2'b10; pb_length = 7'd3; pb_start = 1'b1;
        tick();
        pb_start = 1'b0;
        repeat (5) tick();
        chk("pre_rst_count", 256'(loop_count), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", 256'({fm_vld, pb_busy, pb_done}), 256'(0));
        chk("mid_rst_count", 256'(loop_count), 256'(0));
        chk("mid_rst_fm_data", fm_data, 256'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pb_start = 1'b1;
        tick();
        pb_start = 1'b0;
        chk("post_rst_t1", 256'(fm_vld), 256'(0));
        tick();
        chk("post_rst_data0", fm_data, ent(0));
        tick();
        chk("post_rst_data1", fm_data, ent(1));
        pb_stop = 1'b1;
        tick();
        pb_stop = 1'b0;
        tick();
        tick();
        chk("post_rst_idle", 256'(pb_busy), 256'(0));
        $display("reset mid-stream complete");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fm_sb_playback.md
Name: fm_sb_playback

Overview:
- Playback counterpart of the fast-monitor spy buffer. Capture takes the pipeline fm_data/fm_vld stream into memory for AXI readout; this block runs the other way.
- Software loads monitor-width entries through the same 32-bit AXI memory-port signalling (address/enable/wr_enable/wr_data). The block then replays them as an fm_data/fm_vld stream into the pipeline.
- Sits beside each spy buffer and is selected by the FM playback mode field.

Parameters:
- MON_DW, 256, width of one replayed entry (fm_data width); must be a multiple of AXI_DW.
- AXI_DW, 32, AXI data word width.
- DEPTH, 64, number of entries (power of two).
- ADDR_W, 16, AXI word address width.
- (derived) WPE = MON_DW/AXI_DW words per entry; PTR_W = $clog2(DEPTH).

Ports:
- clk, in, 1, single clock for AXI port and playback.
- rst_n, in, 1, asynchronous active-low reset.
- axi_addr, in, ADDR_W, word address. Entry = addr/WPE, word = addr%WPE; word 0 is the LSBs.
- axi_enable, in, 1, access strobe.
- axi_wr_enable, in, 1, 1 = write, 0 = read (qualified by axi_enable).
- axi_wr_data, in, AXI_DW, write word.
- axi_rd_data, out, AXI_DW, read word.
- axi_rd_vld, out, 1, read data valid pulse.
- axi_wr_err, out, 1, pulse: write was dropped.
- pb_mode, in, 2, 00 off, 01 single-shot, 10 loop, 11 reserved (treated as off).
- pb_start, in, 1, start pulse.
- pb_stop, in, 1, stop pulse.
- pb_length, in, PTR_W+1, number of entries to replay (1..DEPTH).
- fm_data, out, MON_DW, replayed entry.
- fm_vld, out, 1, entry valid.
- pb_busy, out, 1, high while not IDLE.
- pb_done, out, 1, one-cycle pulse when playback ends.
- loop_count, out, 16, completed passes in loop mode; saturates at 0xFFFF.

Behaviour:
- Reset: all outputs 0, FSM IDLE, rd_ptr 0. Memory contents are undefined (not cleared).
- AXI write: axi_enable & axi_wr_enable writes word axi_addr%WPE of entry axi_addr/WPE in the same cycle.
  - Dropped with axi_wr_err=1 the next cycle if axi_addr >= DEPTH*WPE or pb_busy=1.
- AXI read: axi_enable & !axi_wr_enable gives axi_rd_data plus a one-cycle axi_rd_vld one cycle later.
  - Out-of-range reads return 0 with axi_rd_vld=1.
  - Reads are allowed while busy.
  - axi_rd_data holds its last value otherwise.
- FSM states IDLE, PLAY, DRAIN.
- IDLE -> PLAY when pb_start=1, pb_mode is 01 or 10, and 1 <= pb_length <= DEPTH. On entry: rd_ptr=0, loop_count=0, and pb_mode/pb_length are latched.
  - A start under any other condition is ignored; no pb_done is generated.
- PLAY issues one entry read per cycle at rd_ptr. Memory latency is 1: fm_vld=1 and fm_data=entry[rd_ptr] on the following cycle.
  - pb_start at cycle T puts first fm_vld at T+2.
  - The stream is gapless (fm_vld continuous) until the end.
- End of pass (rd_ptr == len-1 issued):
  - Single-shot: go to DRAIN.
  - Loop: rd_ptr wraps to 0 with no bubble, and loop_count increments on that cycle.
- pb_stop=1 in PLAY: no further reads are issued from that cycle; go to DRAIN. A read issued in the same cycle is suppressed.
  - pb_stop and end of pass in the same cycle: stop wins; loop_count does not increment.
- DRAIN: the last issued entry is output. pb_done=1 in the cycle after the final fm_vld, then IDLE.
  - If no read was outstanding (stop on the first PLAY cycle), pb_done fires on the DRAIN cycle.
- pb_start while busy is ignored. pb_mode/pb_length changes while busy are ignored (latched values are used).
- fm_data is 0 whenever fm_vld=0.
- rst_n asserted mid-playback immediately clears fm_vld, pb_busy and pb_done; no pb_done is produced.

Test Plan:
- Load/readback: write entry 3 words 0..7 with 0x3000_0000+k; read addr 24..31 -> same values, each axi_rd_vld one cycle after the request. Read addr 512 (DEPTH=64) -> 0, and a write there -> axi_wr_err pulse.
- Single-shot: entries 0..4 loaded with pattern, pb_length=5, mode 01, start at T -> fm_vld high T+2..T+6 with entries 0..4 in order. pb_done at T+7, pb_busy low at T+7/T+8.
- Loop: pb_length=3, mode 10, run 10 entries -> sequence 0,1,2,0,1,2,0,1,2,0 gapless, loop_count=3. Stop pulse -> at most one further fm_vld, then pb_done; loop_count unchanged.
- Illegal starts: pb_length=0, pb_length=65, mode 00, mode 11 -> no fm_vld, pb_busy stays 0, no pb_done.
- Busy interactions: AXI write during PLAY -> axi_wr_err, memory unchanged (verify by readback after). AXI read during PLAY returns the correct data. Second pb_start ignored.
- Reset mid-stream: rst_n low during loop playback -> fm_vld, pb_busy, loop_count immediately 0. After release, a new start replays from entry 0.
